// File: rtl/boot_wr_if.sv
// Boot-write port from the UART image loader into instruction/data memory.
// One byte write per cycle while en is high; there is no backpressure.
interface boot_wr_if;
    logic        en;
    logic [31:0] addr;
    logic [7:0]  data;

    modport master (output en, addr, data);
    modport slave  (input  en, addr, data);
endinterface

// File: rtl/uart_boot_loader.sv
// Loads a framed program image from UART (A5 | addr[4] | len[2] | payload [| csum]) into memory.
// Optional trailing checksum byte enabled by defining BOOT_CHECKSUM_EN.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CYC  = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    boot_wr_if.master  boot_wr,
    output logic       core_hold,
    output logic       boot_done,
    output logic       boot_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_M1  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       SYNC    = 8'hA5;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] F_HUNT = 3'd0;
    localparam logic [2:0] F_ADDR = 3'd1;
    localparam logic [2:0] F_LEN  = 3'd2;
    localparam logic [2:0] F_DATA = 3'd3;
    localparam logic [2:0] F_CSUM = 3'd4;
    localparam logic [2:0] F_DONE = 3'd5;
    localparam logic [2:0] F_ERR  = 3'd6;

`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] F_POST = F_CSUM;
`else
    localparam logic [2:0] F_POST = F_DONE;
`endif

    logic             rx_meta, rx_sync, rx_prev;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             rx_valid, rx_ferr;

    logic [2:0]       state;
    logic [1:0]       byte_cnt;
    logic [31:0]      base;
    logic [15:0]      len, idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic             timing;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    // NOTE: the synchroniser resets to the idle-high level so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= R_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                R_IDLE: if (rx_prev && !rx_sync) begin
                    rx_state <= R_START;
                    bit_cnt  <= '0;
                end
                R_START: if (bit_cnt == HALF_M1) begin
                    bit_cnt  <= '0;
                    bit_idx  <= '0;
                    rx_state <= rx_sync ? R_IDLE : R_DATA;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                R_DATA: if (bit_cnt == FULL_M1) begin
                    bit_cnt <= '0;
                    rx_byte <= {rx_sync, rx_byte[7:1]};
                    if (bit_idx == 3'd7) rx_state <= R_STOP;
                    else                 bit_idx  <= bit_idx + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                R_STOP: if (bit_cnt == FULL_M1) begin
                    bit_cnt  <= '0;
                    rx_state <= R_IDLE;
                    if (rx_sync) rx_valid <= 1'b1;
                    else         rx_ferr  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    assign timing = (state == F_ADDR) || (state == F_LEN) ||
                    (state == F_DATA) || (state == F_CSUM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= F_HUNT;
            byte_cnt     <= '0;
            base         <= '0;
            len          <= '0;
            idx          <= '0;
            tmo_cnt      <= '0;
            boot_wr.en   <= 1'b0;
            boot_wr.addr <= '0;
            boot_wr.data <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            boot_wr.en <= 1'b0;
            tmo_cnt    <= (timing && !rx_valid) ? tmo_cnt + 1'b1 : '0;
            if (state != F_DONE && rx_ferr) begin
                state <= F_ERR;
            end else if (timing && !rx_valid && tmo_cnt == TMO_M1) begin
                state <= F_ERR;
            end else if (rx_valid) begin
                case (state)
                    F_HUNT, F_ERR: if (rx_byte == SYNC) begin
                        state    <= F_ADDR;
                        byte_cnt <= '0;
                    end
                    F_ADDR: begin
                        base     <= {rx_byte, base[31:8]};
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            state    <= F_LEN;
                            byte_cnt <= '0;
                        end
                    end
                    F_LEN: begin
                        len      <= {rx_byte, len[15:8]};
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd1) begin
                            idx   <= '0;
`ifdef BOOT_CHECKSUM_EN
                            csum  <= '0;
`endif
                            state <= ({rx_byte, len[15:8]} == 16'd0) ? F_POST : F_DATA;
                        end
                    end
                    F_DATA: begin
                        boot_wr.en   <= 1'b1;
                        boot_wr.addr <= base + {16'h0, idx};
                        boot_wr.data <= rx_byte;
                        idx          <= idx + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        csum         <= csum + rx_byte;
`endif
                        if (idx == len - 16'd1) state <= F_POST;
                    end
`ifdef BOOT_CHECKSUM_EN
                    F_CSUM: state <= (rx_byte == csum) ? F_DONE : F_ERR;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Status decodes straight from the frame state so done/hold change in the same cycle.
    assign boot_done = (state == F_DONE);
    assign core_hold = (state != F_DONE);
    assign boot_err  = (state == F_ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader (CLKS_PER_BIT=8, TIMEOUT_CYC=2000); honours BOOT_CHECKSUM_EN.
module tb_uart_boot_loader;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic uart_rx = 1'b1;
    logic core_hold, boot_done, boot_err;
    int total = 0;
    int bad = 0;
    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    logic [7:0]  tx[$];
    logic [7:0]  pl[$];

    boot_wr_if bw();

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(2000)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .boot_wr   (bw),
        .core_hold (core_hold),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bw.en === 1'b1) begin
            wa.push_back(bw.addr);
            wd.push_back(bw.data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (stop ? CPB : 3 * CPB) @(negedge clk);
    endtask

    task automatic send_tx();
        foreach (tx[i]) send_byte(tx[i], 1'b1);
        repeat (4) @(negedge clk);
    endtask

    // Frame around pl; delta perturbs the checksum byte when checksums are enabled.
    task automatic send_frame(input logic [31:0] base, input logic [7:0] delta);
        logic [7:0] s;
        s = delta;
        tx.delete();
        tx.push_back(8'hA5);
        for (int i = 0; i < 4; i++) tx.push_back(base[8*i +: 8]);
        tx.push_back(8'(pl.size()));
        tx.push_back(8'(pl.size() >> 8));
        foreach (pl[i]) begin
            tx.push_back(pl[i]);
            s = s + pl[i];
        end
`ifdef BOOT_CHECKSUM_EN
        tx.push_back(s);
`endif
        send_tx();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        wa.delete();
        wd.delete();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frame1(input string tag);
        logic [7:0] f1 [4];
        f1 = '{8'h13, 8'h00, 8'h00, 8'h00};
        check({tag, "_nwr"}, wa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_addr"}, (i < wa.size()) ? wa[i] : 32'hDEAD_BEEF, i);
            check({tag, "_data"}, (i < wd.size()) ? {24'h0, wd[i]} : 32'hDEAD_BEEF, {24'h0, f1[i]});
        end
        check({tag, "_done"}, boot_done, 1);
        check({tag, "_hold"}, core_hold, 0);
        check({tag, "_err"}, boot_err, 0);
    endtask

    initial begin
        // Reset values while reset is held
        repeat (2) @(negedge clk);
        check("rst_hold", core_hold, 1);
        check("rst_done", boot_done, 0);
        check("rst_err", boot_err, 0);
        check("rst_en", bw.en, 0);
        check("rst_addr", bw.addr, 0);
        check("rst_data", {24'h0, bw.data}, 0);
        do_reset();

        // 1: basic image
        pl = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_frame(32'h0, 8'h00);
        check_frame1("t1");

        // 2: bad frame then retry without reset
        do_reset();
`ifdef BOOT_CHECKSUM_EN
        send_frame(32'h0, 8'h01);
        check("t2_bad_nwr", wa.size(), 4);
`else
        tx = '{8'hA5};
        send_tx();
        send_byte(8'h00, 1'b0);
        check("t2_bad_nwr", wa.size(), 0);
`endif
        check("t2_bad_err", boot_err, 1);
        check("t2_bad_hold", core_hold, 1);
        check("t2_bad_done", boot_done, 0);
        wa.delete();
        wd.delete();
        send_frame(32'h0, 8'h00);
        check_frame1("t2_retry");

        // 3: junk before the sync byte
        do_reset();
        tx = '{8'h00, 8'hFF, 8'h5A};
        send_tx();
        check("t3_junk_nwr", wa.size(), 0);
        check("t3_junk_err", boot_err, 0);
        check("t3_junk_done", boot_done, 0);
        send_frame(32'h0, 8'h00);
        check_frame1("t3");

        // 4: address wrap past 2^32
        do_reset();
        pl = '{8'h01, 8'h02, 8'h03};
        send_frame(32'hFFFF_FFFE, 8'h00);
        check("t4_nwr", wa.size(), 3);
        check("t4_a0", (wa.size() > 0) ? wa[0] : 32'h0BAD, 32'hFFFF_FFFE);
        check("t4_a1", (wa.size() > 1) ? wa[1] : 32'h0BAD, 32'hFFFF_FFFF);
        check("t4_a2", (wa.size() > 2) ? wa[2] : 32'h0BAD, 32'h0000_0000);
        check("t4_d2", (wd.size() > 2) ? {24'h0, wd[2]} : 32'h0BAD, 32'h03);
        check("t4_done", boot_done, 1);

        // Zero-length image
        do_reset();
        pl.delete();
        send_frame(32'h100, 8'h00);
        check("n0_nwr", wa.size(), 0);
        check("n0_done", boot_done, 1);
        check("n0_hold", core_hold, 0);

        // 5a: framing error on the 2nd address byte
        do_reset();
        tx = '{8'hA5, 8'h00};
        send_tx();
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check("t5_ferr_err", boot_err, 1);
        check("t5_ferr_nwr", wa.size(), 0);
        check("t5_ferr_hold", core_hold, 1);

        // 5b: inter-byte timeout mid-payload
        do_reset();
        tx = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22};
        send_tx();
        repeat (1500) @(negedge clk);
        check("t5_tmo_early", boot_err, 0);
        repeat (1000) @(negedge clk);
        check("t5_tmo_err", boot_err, 1);
        check("t5_tmo_nwr", wa.size(), 2);

        // 6: asynchronous reset mid-payload
        do_reset();
        tx = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'hAA, 8'hBB};
        send_tx();
        check("t6_pre_addr", bw.addr, 32'h11);
        check("t6_pre_data", {24'h0, bw.data}, 32'hBB);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_addr", bw.addr, 0);
        check("t6_rst_data", {24'h0, bw.data}, 0);
        check("t6_rst_en", bw.en, 0);
        check("t6_rst_hold", core_hold, 1);
        check("t6_rst_done", boot_done, 0);
        check("t6_rst_err", boot_err, 0);
        @(negedge clk);
        wa.delete();
        wd.delete();
        reset = 1'b1;
        @(negedge clk);
        pl = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_frame(32'h0, 8'h00);
        check_frame1("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
